pc_irq_injector: RTL

- Synthesisable, table-driven interrupt stimulus generator for the CPU test harness.
- Watches macroscopic_pc and raises one of NUM_CH external interrupt lines when the PC reaches the next entry of a programmable trigger table.
- Clears interrupts on a CPU store to the acknowledge address.
- Replaces hand-written per-address interrupt sequences. Adds multiple channels, pulse mode, table wrap and fire/coalesce statistics.

---
 rtl/pc_irq_injector_pkg.sv | 28 ++
 rtl/pc_irq_injector_irq_line_ctrl.sv | 48 ++++
 rtl/pc_irq_injector.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_irq_injector_pkg.sv
// Shared types and helpers for the PC-triggered interrupt injector.
// Trigger entries keep only the word part of the PC; channel field is wide enough for any NUM_CH up to 256.
package pc_irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int CH_FIELD_W = 8;

  typedef struct packed {
    logic [29:0]           pc;
    logic [CH_FIELD_W-1:0] ch;
  } entry_t;

  localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7F20;

  function automatic logic word_match(input logic [31:0] addr, input logic [29:0] word);
    return addr[31:2] == word;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_irq_injector_irq_line_ctrl.sv
// One interrupt line: level (set by fire, cleared by ack) or fixed-width pulse.
// A fire in the same cycle as an ack always wins.
module irq_line_ctrl
  import pc_irq_pkg::*;
#(
  parameter bit PULSE_MODE = 1'b0,
  parameter int PULSE_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fire_i,
  input  logic ack_i,
  output logic irq_o
);

  localparam logic [7:0] LOAD_VAL = 8'(PULSE_LEN);

  logic [7:0] cnt_q, cnt_d;

  // Level mode only ever holds 0 or 1 in the counter, so irq is "counter non-zero" in both modes.
  always_comb begin
    cnt_d = cnt_q;
    if (PULSE_MODE) begin
      if (fire_i) begin
        cnt_d = LOAD_VAL;
      end else if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end
    end else begin
      if (fire_i) begin
        cnt_d = 8'd1;
      end else if (ack_i) begin
        cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign irq_o = (cnt_q != 8'd0);

endmodule

// File: rtl/pc_irq_injector.sv
// Table-driven interrupt stimulus: fires irq[tbl[ptr].ch] when the CPU PC hits tbl[ptr].pc, acked by a store.
// state | meaning
// IDLE  | waiting for arm, no fires
// ARMED | comparing PC against tbl[ptr]; busy=1
// DONE  | table exhausted (or armed with zero entries); done=1
module pc_irq_injector
  import pc_irq_pkg::*;
#(
  parameter int          NUM_CH     = 6,
  parameter int          DEPTH      = 128,
  parameter logic [31:0] ACK_ADDR   = ACK_ADDR_DEFAULT,
  parameter bit          PULSE_MODE = 1'b0,
  parameter int          PULSE_LEN  = 4,
  parameter bit          ACK_ALL    = 1'b1,
  parameter bit          WRAP       = 1'b0
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          tbl_we,
  input  logic [$clog2(DEPTH)-1:0]                      tbl_idx,
  input  logic [31:0]                                   tbl_pc,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] tbl_ch,
  input  logic                                          arm,
  input  logic [$clog2(DEPTH):0]                        arm_count,
  input  logic [31:0]                                   macroscopic_pc,
  input  logic [31:0]                                   m_data_addr,
  input  logic [3:0]                                    m_data_byteen,
  input  logic [31:0]                                   m_data_wdata,
  output logic [NUM_CH-1:0]                             irq,
  output logic                                          busy,
  output logic                                          done,
  output logic [15:0]                                   fire_cnt,
  output logic [15:0]                                   coalesce_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  entry_t           tbl_q [DEPTH];
  entry_t           cur_entry;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ptr_inc;
  logic [15:0]      fire_cnt_q, fire_cnt_d;
  logic [15:0]      coal_cnt_q, coal_cnt_d;

  logic              match, fire, coalesce, ack_hit;
  logic [NUM_CH-1:0] fire_vec, ack_vec, irq_vec;
  logic              unused_bits;

  // Table RAM is deliberately not reset; writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[tbl_idx] <= '{pc: tbl_pc[31:2], ch: CH_FIELD_W'(tbl_ch)};
    end
  end

  assign cur_entry = tbl_q[ptr_q];
  assign match     = (state_q == ARMED) && word_match(macroscopic_pc, cur_entry.pc);
  // A same-cycle arm restarts the table, so it suppresses the fire of the old entry.
  assign fire      = match && !arm;
  assign ack_hit   = (|m_data_byteen) && word_match(m_data_addr, ACK_ADDR[31:2]);
  assign ptr_inc   = {1'b0, ptr_q} + CNT_W'(1);

  always_comb begin
    fire_vec = '0;
    ack_vec  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire_vec[i] = fire && (cur_entry.ch == CH_FIELD_W'(i));
      ack_vec[i]  = !PULSE_MODE && ack_hit && (ACK_ALL || m_data_wdata[i]);
    end
  end

  assign coalesce = |(fire_vec & irq_vec);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    fire_cnt_d = fire_cnt_q;
    coal_cnt_d = coal_cnt_q;

    case (state_q)
      ARMED: begin
        if (fire) begin
          fire_cnt_d = sat_inc16(fire_cnt_q);
          if (coalesce) begin
            coal_cnt_d = sat_inc16(coal_cnt_q);
          end
          if (ptr_inc >= count_q) begin
            ptr_d = '0;
            if (!WRAP) begin
              state_d = DONE;
            end
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      IDLE, DONE: ;
      default: state_d = IDLE;
    endcase

    // arm is honoured from every state and always clears the statistics.
    if (arm) begin
      ptr_d      = '0;
      fire_cnt_d = 16'd0;
      coal_cnt_d = 16'd0;
      count_d    = (arm_count > DEPTH_CNT) ? DEPTH_CNT : arm_count;
      state_d    = (arm_count != '0) ? ARMED : DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      fire_cnt_q <= 16'd0;
      coal_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      fire_cnt_q <= fire_cnt_d;
      coal_cnt_q <= coal_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_line
    irq_line_ctrl #(
      .PULSE_MODE(PULSE_MODE),
      .PULSE_LEN (PULSE_LEN)
    ) u_line (
      .clk   (clk),
      .reset (reset),
      .fire_i(fire_vec[g]),
      .ack_i (ack_vec[g]),
      .irq_o (irq_vec[g])
    );
  end

  assign irq          = irq_vec;
  assign busy         = (state_q == ARMED);
  assign done         = (state_q == DONE);
  assign fire_cnt     = fire_cnt_q;
  assign coalesce_cnt = coal_cnt_q;

  assign unused_bits = ^{tbl_pc[1:0], macroscopic_pc[1:0], m_data_addr[1:0], m_data_wdata};

endmodule
